fir_frame_sequencer: RTL and testbench
======================================

// Module: fir_frame_sequencer
// PURPOSE
//  Frame-level sequencer for the 16-bit streaming fir_filter.
//  - Start: pulse fir_rst for 1 cycle to clear filter history.
//  - Feed: pass frame_len upstream samples (valid/ready) into the filter.
//  - Flush: append TAPS-1 zero samples so the full convolution tail emerges.
//  - Output: count filter outputs, forward them with m_last, then pulse done.
// PARAMETERS
//  DATA_W   16    sample width, signed two's complement, in and out
//  LEN_W    10    width of frame_len and of the sample/output counters
//  TAPS     4     filter tap count; flush length = TAPS-1 (TAPS>=2)
//  TIMEOUT  256   max cycles in DRAIN without a fir_valid_out before abort
// PORTS
//  clk            in   1       single clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  start          in   1       frame request; sampled only in IDLE
//  frame_len      in   LEN_W   input samples in frame; captured on accepted start
//  s_data         in   DATA_W  upstream sample
//  s_valid        in   1       upstream sample valid
//  s_ready        out  1       sequencer accepts sample (FEED only)
//  fir_rst        out  1       to fir_filter.rst: rst OR 1-cycle clear pulse
//  fir_in         out  DATA_W  to fir_filter.input_signal (registered)
//  fir_valid_in   out  1       to fir_filter.valid_in (registered)
//  fir_out        in   DATA_W  from fir_filter.output_signal
//  fir_valid_out  in   1       from fir_filter.valid_out
//  m_data         out  DATA_W  filtered sample (registered copy of fir_out)
//  m_valid        out  1       m_data valid; no backpressure
//  m_last         out  1       with m_valid on final output of frame
//  busy           out  1       high in every state except IDLE
//  done           out  1       1-cycle pulse: frame complete or aborted
//  err            out  1       1-cycle pulse with done on timeout abort
// BEHAVIOUR
//  Reset: all outputs 0, except fir_rst=1 while rst high. State IDLE, counters 0.
//  FSM: IDLE -> CLEAR -> FEED -> FLUSH -> DRAIN -> IDLE.
//  - IDLE: start && frame_len!=0 -> CLEAR; latch len, set total=len+TAPS-1.
//    start && frame_len==0 -> done=1 next cycle, stay IDLE, filter untouched.
//    start while busy is ignored.
//  - CLEAR: fir_rst=1 for exactly 1 cycle; in_cnt=out_cnt=0; -> FEED.
//  - FEED: s_ready=1. On s_valid&&s_ready, next cycle fir_in=s_data and
//    fir_valid_in=1; otherwise fir_valid_in=0 (filter holds; gaps allowed).
//    Accept of sample len-1 -> FLUSH; s_ready drops in the same edge.
//  - FLUSH: fir_in=0, fir_valid_in=1 for exactly TAPS-1 consecutive cycles -> DRAIN.
//  - DRAIN: fir_valid_in=0; wait for out_cnt==total.
//    TIMEOUT cycles with no fir_valid_out -> done=1, err=1, -> IDLE.
//  - Output path, all states after CLEAR: each fir_valid_out gives, 1 cycle
//    later, m_valid=1 and m_data=fir_out; out_cnt++.
//    m_last=1 when out_cnt==total-1.
//    done pulses the cycle after m_last; FSM returns to IDLE on that cycle.
//  - fir_valid_out in IDLE/CLEAR is dropped: no m_valid.
//    Outputs beyond total are dropped.
//  - Latency start->first fir_valid_in = 3 cycles with s_valid held high:
//    CLEAR, then FEED accept, then register.
//  - Counters are LEN_W+1 bits; total never wraps.
//    frame_len=2^LEN_W-1 must complete correctly.
//  - rst asserted mid-frame: immediate IDLE, all outputs 0.
//    No done pulse; the partial frame is lost.
// STRUCTURE
//  - Shared package fir_pkg: DATA_W, TAPS, state enum (IDLE, CLEAR, FEED,
//    FLUSH, DRAIN), LEN_W.
//  - One sub-module is natural: fir_out_tracker (output counter,
//    m_valid/m_data/m_last register, done, timeout counter).
//  - FSM and input path stay in this module.
// TESTING
//  Bench instantiates fir_filter, or a model with all coefficients 1 (moving sum, TAPS=4).
//  1 Frame: len=5, samples 1,2,3,4,5 back-to-back
//    -> fir_in 1,2,3,4,5,0,0,0; m_data 1,3,6,10,14,12,9,5; m_last on 5;
//    done 1 cycle later.
//  2 Gaps: same frame, s_valid low every other cycle
//    -> identical m_data; fir_valid_in low in gap cycles; s_ready high through FEED.
//  3 Zero length: start with frame_len=0
//    -> done 1 cycle later; fir_rst never pulses; busy stays 0.
//  4 Re-start: start held high while busy
//    -> ignored; second frame len=1, x=7 -> fir_rst pulse,
//    m_data 7,7,7,7 (no history carried over).
//  5 Timeout: model never raises valid_out, TIMEOUT=16
//    -> done=1 and err=1 in the same cycle, 16 cycles after DRAIN entry.
//  6 Reset: rst at the 3rd FEED sample
//    -> all outputs 0 asynchronously; no done; next frame runs clean.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR frame sequencer.
package fir_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned LEN_W   = 10;
    localparam int unsigned TAPS    = 4;
    localparam int unsigned TIMEOUT = 256;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN
    } state_t;

endpackage

// File: rtl/fir_out_tracker.sv
// Output side of the FIR frame sequencer: counts filter outputs, registers
// them towards the consumer, and raises done/err at frame end or on a stall.
module fir_out_tracker
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W  = fir_pkg::DATA_W,
    parameter int unsigned CNT_W   = fir_pkg::LEN_W + 1,
    parameter int unsigned TIMEOUT = fir_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              drain,
    input  logic              zero_req,
    input  logic [CNT_W-1:0]  total,
    input  logic [DATA_W-1:0] fir_out,
    input  logic              fir_valid_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic              done,
    output logic              err,
    output logic              fin,
    output logic              abort
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] out_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             take;

    // Outputs before CLEAR or beyond the frame total are silently dropped.
    assign take  = en && fir_valid_out && (out_cnt < total);
    assign fin   = m_valid && m_last;
    assign abort = drain && !fir_valid_out && !fin && (to_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
            to_cnt  <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            m_valid <= take;
            m_last  <= take && (out_cnt == total - 1'b1);
            m_data  <= take ? fir_out : '0;
            done    <= fin || abort || zero_req;
            err     <= abort;

            if (clr)
                out_cnt <= '0;
            else if (take)
                out_cnt <= out_cnt + 1'b1;

            if (!drain || fir_valid_out)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fir_frame_sequencer.sv
// Frame-level sequencer for a streaming FIR filter: clears the filter, feeds
// one frame of samples, flushes the tail with zeros and tracks the outputs.
module fir_frame_sequencer #(
    parameter int unsigned DATA_W  = fir_pkg::DATA_W,
    parameter int unsigned LEN_W   = fir_pkg::LEN_W,
    parameter int unsigned TAPS    = fir_pkg::TAPS,
    parameter int unsigned TIMEOUT = fir_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              fir_rst,
    output logic [DATA_W-1:0] fir_in,
    output logic              fir_valid_in,
    input  logic [DATA_W-1:0] fir_out,
    input  logic              fir_valid_out,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import fir_pkg::*;

    localparam int unsigned CNT_W = LEN_W + 1;
    localparam int unsigned FL_W  = (TAPS > 2) ? $clog2(TAPS - 1) : 1;

    state_t           state, next_state;
    logic [CNT_W-1:0] len, total, in_cnt;
    logic [FL_W-1:0]  flush_cnt;
    logic             accept, last_in, flush_end, start_ok;
    logic             zero_req, clr, en, drain, fin, abort;

    assign accept    = s_valid && s_ready;
    assign last_in   = (in_cnt == len - 1'b1);
    assign flush_end = (flush_cnt == FL_W'(TAPS - 2));
    assign start_ok  = start && (frame_len != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = CLEAR;
            CLEAR:   next_state = FEED;
            FEED:    if (accept && last_in) next_state = FLUSH;
            FLUSH:   if (flush_end) next_state = DRAIN;
            DRAIN:   if (fin || abort) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_ready  = (state == FEED);
        busy     = (state != IDLE);
        clr      = (state == CLEAR);
        fir_rst  = rst || (state == CLEAR);
        en       = (state == FEED) || (state == FLUSH) || (state == DRAIN);
        drain    = (state == DRAIN);
        zero_req = (state == IDLE) && start && (frame_len == '0);
    end

    // Filter input is registered, so each FLUSH cycle's zero reaches the
    // filter one cycle later; the last zero therefore lands in the first DRAIN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len          <= '0;
            total        <= '0;
            in_cnt       <= '0;
            flush_cnt    <= '0;
            fir_in       <= '0;
            fir_valid_in <= 1'b0;
        end else begin
            fir_in       <= '0;
            fir_valid_in <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len   <= CNT_W'(frame_len);
                        total <= CNT_W'(frame_len) + CNT_W'(TAPS - 1);
                    end
                end
                CLEAR: begin
                    in_cnt    <= '0;
                    flush_cnt <= '0;
                end
                FEED: begin
                    if (accept) begin
                        fir_in       <= s_data;
                        fir_valid_in <= 1'b1;
                        in_cnt       <= in_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    fir_valid_in <= 1'b1;
                    flush_cnt    <= flush_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    fir_out_tracker #(
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_out_tracker (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .clr           (clr),
        .drain         (drain),
        .zero_req      (zero_req),
        .total         (total),
        .fir_out       (fir_out),
        .fir_valid_out (fir_valid_out),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .done          (done),
        .err           (err),
        .fin           (fin),
        .abort         (abort)
    );

endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Self-checking bench for fir_frame_sequencer with a 4-tap all-ones filter
// model; expectations come from a direct convolution of each frame.
module tb_fir_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  frame_len;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        fir_rst;
    logic [15:0] fir_in;
    logic        fir_valid_in;
    logic [15:0] fir_out;
    logic        fir_valid_out;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        err;

    logic        no_out;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    logic [15:0] xs[$];
    logic [15:0] fin_q[$];
    int          fin_cyc_q[$];
    logic [15:0] m_q[$];
    logic        ml_q[$];
    int          mlast_cyc = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    logic        done_err  = 1'b0;
    int          clr_cnt   = 0;
    int          busy_cyc  = 0;

    fir_frame_sequencer #(
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .frame_len     (frame_len),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .fir_rst       (fir_rst),
        .fir_in        (fir_in),
        .fir_valid_in  (fir_valid_in),
        .fir_out       (fir_out),
        .fir_valid_out (fir_valid_out),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Filter stand-in: moving sum over the last four accepted inputs.
    logic [15:0] hist [0:2];
    always @(posedge clk) begin
        if (fir_rst) begin
            hist[0]       <= '0;
            hist[1]       <= '0;
            hist[2]       <= '0;
            fir_out       <= '0;
            fir_valid_out <= 1'b0;
        end else begin
            fir_valid_out <= fir_valid_in && !no_out;
            if (fir_valid_in) begin
                fir_out <= fir_in + hist[0] + hist[1] + hist[2];
                hist[0] <= fir_in;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fir_valid_in) begin
                fin_q.push_back(fir_in);
                fin_cyc_q.push_back(cyc);
            end
            if (m_valid) begin
                m_q.push_back(m_data);
                ml_q.push_back(m_last);
                if (m_last) mlast_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_err = err;
            end
            if (fir_rst) clr_cnt++;
            if (busy) busy_cyc++;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_y(input int k);
        logic [15:0] s;
        s = '0;
        for (int j = 0; j < 4; j++)
            if (k - j >= 0 && k - j < xs.size()) s = s + xs[k - j];
        return s;
    endfunction

    task automatic rand_frame(input int n);
        xs.delete();
        for (int i = 0; i < n; i++) xs.push_back(16'($urandom));
    endtask

    task automatic run_frame(input int gap, input bit hold, input bit tmo);
        int n, fb, mb, db, cb, idx, cy, sc, w, lastpos, lastcnt, bad_ready, nf, nm;
        n = xs.size(); fb = fin_q.size(); mb = m_q.size(); db = done_cnt; cb = clr_cnt;
        idx = 0; cy = 0; bad_ready = 0;
        @(posedge clk); #1;
        start = 1'b1; frame_len = 10'(n); s_valid = 1'b1; s_data = xs[0]; sc = cyc;
        while (idx < n && cy < 4 * n + 50) begin
            @(negedge clk);
            if (idx > 0 && !s_ready) bad_ready++;
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
            cy++;
            if (!hold) start = 1'b0;
            case (gap)
                1:       s_valid = (cy % 2 == 0);
                2:       s_valid = 1'($urandom_range(0, 1));
                default: s_valid = 1'b1;
            endcase
            if (idx < n) s_data = xs[idx];
            else begin s_valid = 1'b0; s_data = '0; end
        end
        start = 1'b0; s_valid = 1'b0;
        check_eq("feed_count", idx, n);
        check_eq("s_ready_feed", bad_ready, 0);
        @(negedge clk); #1;
        check_eq("s_ready_drop", s_ready, 0);
        w = 0;
        while (done_cnt == db && w < 300) begin @(negedge clk); #1; w++; end
        repeat (3) @(negedge clk);
        #1;
        check_eq("done_once", done_cnt - db, 1);
        check_eq("busy_after", busy, 0);
        check_eq("clear_pulse", clr_cnt - cb, 1);
        nf = fin_q.size() - fb;
        nm = m_q.size() - mb;
        check_eq("fir_in_count", nf, n + 3);
        for (int i = 0; i < n + 3 && i < nf; i++)
            check_eq("fir_in", fin_q[fb + i], (i < n) ? xs[i] : 16'd0);
        if (gap == 0 && nf > 0) check_eq("latency", fin_cyc_q[fb] - sc, 3);
        if (tmo) begin
            check_eq("tmo_m_count", nm, 0);
            check_eq("tmo_err", done_err, 1);
            if (nf > 0) check_eq("tmo_cycles", done_cyc - fin_cyc_q[fin_cyc_q.size() - 1], 16);
        end else begin
            check_eq("m_count", nm, n + 3);
            lastpos = -1; lastcnt = 0;
            for (int i = 0; i < n + 3 && i < nm; i++) begin
                check_eq("m_data", m_q[mb + i], ref_y(i));
                if (ml_q[mb + i]) begin lastcnt++; lastpos = i; end
            end
            check_eq("m_last_cnt", lastcnt, 1);
            check_eq("m_last_pos", lastpos, n + 2);
            check_eq("done_after_last", done_cyc - mlast_cyc, 1);
            check_eq("no_err", done_err, 0);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int db, cb, bc, sc, idx, cy;
        rst = 1'b1; start = 1'b0; frame_len = '0; s_valid = 1'b0; s_data = '0; no_out = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_eq("reset_fir_rst", fir_rst, 1);
        check_eq("reset_outs", {busy, s_ready, fir_valid_in, m_valid, m_last, done, err}, 0);
        check_eq("reset_data", {fir_in, m_data}, 0);
        rst = 1'b0;
        @(negedge clk); #1;
        check_eq("idle_fir_rst", fir_rst, 0);

        // Frame 1..5 back-to-back, then with gaps.
        xs = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        run_frame(0, 1'b0, 1'b0);
        run_frame(1, 1'b0, 1'b0);

        // Zero-length request.
        db = done_cnt; cb = clr_cnt; bc = busy_cyc;
        @(posedge clk); #1;
        start = 1'b1; frame_len = '0; sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        check_eq("zl_done", done_cnt - db, 1);
        check_eq("zl_done_cyc", done_cyc, sc + 1);
        repeat (4) @(negedge clk);
        #1;
        check_eq("zl_no_clear", clr_cnt - cb, 0);
        check_eq("zl_no_busy", busy_cyc - bc, 0);
        check_eq("zl_done_once", done_cnt - db, 1);
        check_eq("zl_no_err", done_err, 0);

        // Start held through a busy frame, then a fresh single-sample frame.
        rand_frame(6);
        run_frame(0, 1'b1, 1'b0);
        xs = {16'd7};
        run_frame(0, 1'b0, 1'b0);

        // Filter never answers: timeout abort.
        rand_frame(3);
        no_out = 1'b1;
        run_frame(0, 1'b0, 1'b1);
        no_out = 1'b0;

        // Reset while the third sample is on offer.
        rand_frame(8);
        db = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; frame_len = 10'd8; s_valid = 1'b1; s_data = xs[0];
        idx = 0; cy = 0;
        while (idx < 2 && cy < 20) begin
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
            cy++;
            start = 1'b0;
            s_data = xs[idx];
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_fir_rst", fir_rst, 1);
        check_eq("midrst_outs", {busy, s_ready, fir_valid_in, m_valid, m_last, done, err}, 0);
        check_eq("midrst_data", {fir_in, m_data}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; s_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("midrst_no_done", done_cnt - db, 0);
        check_eq("midrst_idle", busy, 0);
        rand_frame(5);
        run_frame(0, 1'b0, 1'b0);

        // Random lengths with random input gaps.
        for (int k = 0; k < 6; k++) begin
            rand_frame(int'($urandom_range(1, 20)));
            run_frame(2, 1'b0, 1'b0);
        end

        // Longest frame the length field allows.
        rand_frame(1023);
        run_frame(0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
